// File: rtl/fib_seq_pkg.sv
// Shared types for the generalised-Fibonacci sequence engine.
package fib_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      LAST = 2'd2,
      DONE = 2'd3
   } state_t;

   typedef enum logic {
      WRAP = 1'b0,
      SAT  = 1'b1
   } arith_mode_t;

endpackage

// File: rtl/fib_seq_step.sv
// One recurrence step: next = a + b with wrap or saturate, plus the raw carry-out.
module fib_seq_step #(
   parameter int OUTPUT_WIDTH = 32
) (
   input  logic [OUTPUT_WIDTH-1:0] a,
   input  logic [OUTPUT_WIDTH-1:0] b,
   input  logic                    sat,
   output logic [OUTPUT_WIDTH-1:0] next,
   output logic                    carry
);

   logic [OUTPUT_WIDTH:0] sum;

   assign sum   = {1'b0, a} + {1'b0, b};
   assign carry = sum[OUTPUT_WIDTH];
   assign next  = (sat && carry) ? '1 : sum[OUTPUT_WIDTH-1:0];

endmodule

// File: rtl/fib_seq_gen.sv
// Generalised-Fibonacci engine: returns a(n) or streams a(0)..a(n) over valid/ready,
// with wrap/saturate arithmetic and a per-job sticky overflow flag.
module fib_seq_gen
   import fib_seq_pkg::*;
#(
   parameter int INPUT_WIDTH  = 6,
   parameter int OUTPUT_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    go,
   input  logic [INPUT_WIDTH-1:0]  n,
   input  logic [OUTPUT_WIDTH-1:0] seed0,
   input  logic [OUTPUT_WIDTH-1:0] seed1,
   input  logic                    sat_mode,
   input  logic                    stream_mode,
   output logic                    busy,
   output logic [OUTPUT_WIDTH-1:0] result,
   output logic [INPUT_WIDTH-1:0]  result_idx,
   output logic                    result_valid,
   input  logic                    result_ready,
   output logic                    overflow,
   output logic                    done
);

   // Handshake: a term transfers on any rising edge where result_valid && result_ready;
   // while valid is high and ready is low, valid/result/result_idx hold unchanged.

   state_t                  state_q, state_d;
   logic [OUTPUT_WIDTH-1:0] a_q, a_d;
   logic [OUTPUT_WIDTH-1:0] b_q, b_d;
   logic                    b_ovf_q, b_ovf_d;
   logic [INPUT_WIDTH-1:0]  k_q, k_d;
   logic [INPUT_WIDTH-1:0]  n_q, n_d;
   arith_mode_t             mode_q, mode_d;
   logic                    stream_q, stream_d;
   logic                    ovf_q, ovf_d;

   logic [OUTPUT_WIDTH-1:0] step_next;
   logic                    step_carry;

   fib_seq_step #(
      .OUTPUT_WIDTH (OUTPUT_WIDTH)
   ) u_step (
      .a     (a_q),
      .b     (b_q),
      .sat   (mode_q == SAT),
      .next  (step_next),
      .carry (step_carry)
   );

   always_comb begin
      state_d      = state_q;
      a_d          = a_q;
      b_d          = b_q;
      b_ovf_d      = b_ovf_q;
      k_d          = k_q;
      n_d          = n_q;
      mode_d       = mode_q;
      stream_d     = stream_q;
      ovf_d        = ovf_q;
      result_valid = 1'b0;
      done         = 1'b0;

      case (state_q)
         IDLE: begin
            if (go) begin
               a_d      = seed0;
               b_d      = seed1;
               b_ovf_d  = 1'b0;
               k_d      = '0;
               n_d      = n;
               mode_d   = arith_mode_t'(sat_mode);
               stream_d = stream_mode;
               ovf_d    = 1'b0;
               state_d  = RUN;
            end
         end
         RUN: begin
            if (k_q == n_q) begin
               state_d = LAST;
            end else begin
               // Term n is presented only from LAST, so it is never offered twice.
               result_valid = stream_q;
               if (!stream_q || result_ready) begin
                  a_d     = b_q;
                  b_d     = step_next;
                  b_ovf_d = step_carry;
                  k_d     = k_q + INPUT_WIDTH'(1);
                  // Overflow follows the term moving into a_q, so a(n+1) never counts.
                  ovf_d   = ovf_q | b_ovf_q;
               end
            end
         end
         LAST: begin
            result_valid = 1'b1;
            if (result_ready) state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         b_ovf_q  <= 1'b0;
         k_q      <= '0;
         n_q      <= '0;
         mode_q   <= WRAP;
         stream_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         b_ovf_q  <= b_ovf_d;
         k_q      <= k_d;
         n_q      <= n_d;
         mode_q   <= mode_d;
         stream_q <= stream_d;
         ovf_q    <= ovf_d;
      end
   end

   // In LAST k_q equals n_q, and both registers hold after DONE until the next go.
   assign busy       = (state_q != IDLE);
   assign result     = a_q;
   assign result_idx = k_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Directed and randomized jobs for fib_seq_gen, checked against an arithmetic reference model.
module tb_fib_seq_gen;

   localparam int IW = 6;
   localparam int OW = 32;
   localparam longint unsigned MAXV = 64'h0000_0000_FFFF_FFFF;
   localparam longint unsigned CAP  = 64'h0000_0002_0000_0000;

   logic          clk          = 1'b0;
   logic          rst_n        = 1'b0;
   logic          go           = 1'b0;
   logic [IW-1:0] n            = '0;
   logic [OW-1:0] seed0        = '0;
   logic [OW-1:0] seed1        = '0;
   logic          sat_mode     = 1'b0;
   logic          stream_mode  = 1'b0;
   logic          result_ready = 1'b0;
   logic          busy;
   logic [OW-1:0] result;
   logic [IW-1:0] result_idx;
   logic          result_valid;
   logic          overflow;
   logic          done;

   fib_seq_gen #(
      .INPUT_WIDTH  (IW),
      .OUTPUT_WIDTH (OW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .go           (go),
      .n            (n),
      .seed0        (seed0),
      .seed1        (seed1),
      .sat_mode     (sat_mode),
      .stream_mode  (stream_mode),
      .busy         (busy),
      .result       (result),
      .result_idx   (result_idx),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .overflow     (overflow),
      .done         (done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [OW-1:0]   exp_q[$];
   logic [IW-1:0]   exp_idx_q[$];
   logic [OW-1:0]   mterm[0:63];
   bit              movf;
   longint unsigned tv[0:63];
   logic [OW-1:0]   wv[0:63];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Exact values clamped above 2^32: sat term = min(true, max), wrap term = true mod 2^32.
   task automatic model(input int nn, input logic [OW-1:0] s0, input logic [OW-1:0] s1, input bit sat);
      tv[0] = {32'd0, s0};
      tv[1] = {32'd0, s1};
      wv[0] = s0;
      wv[1] = s1;
      for (int k = 2; k <= nn; k++) begin
         tv[k] = tv[k-1] + tv[k-2];
         if (tv[k] > CAP) tv[k] = CAP;
         wv[k] = wv[k-1] + wv[k-2];
      end
      movf = 1'b0;
      for (int k = 0; k <= nn; k++) begin
         if (tv[k] > MAXV) movf = 1'b1;
         if (sat) mterm[k] = (tv[k] > MAXV) ? 32'hFFFF_FFFF : tv[k][31:0];
         else     mterm[k] = wv[k];
      end
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_busy"},   busy,         0);
      check({tag, "_result"}, result,       0);
      check({tag, "_idx"},    result_idx,   0);
      check({tag, "_valid"},  result_valid, 0);
      check({tag, "_ovf"},    overflow,     0);
      check({tag, "_done"},   done,         0);
   endtask

   // rmode: 0 always ready, 1 toggling ready, 2 random ready. poke drives go while busy.
   task automatic run_job(input string tag, input int nn, input logic [OW-1:0] s0,
                          input logic [OW-1:0] s1, input bit sat, input bit strm,
                          input int rmode, input bit poke);
      int            cyc;
      int            first_valid;
      bit            prev_stall;
      bit            got_done;
      logic [OW-1:0] prev_res;
      logic [IW-1:0] prev_idx;
      logic [IW-1:0] nb;

      nb = nn[IW-1:0];
      model(nn, s0, s1, sat);
      exp_q.delete();
      exp_idx_q.delete();
      if (strm) begin
         for (int k = 0; k <= nn; k++) begin
            exp_q.push_back(mterm[k]);
            exp_idx_q.push_back(k[IW-1:0]);
         end
      end else begin
         exp_q.push_back(mterm[nn]);
         exp_idx_q.push_back(nb);
      end

      go = 1'b1; n = nb; seed0 = s0; seed1 = s1; sat_mode = sat; stream_mode = strm;
      result_ready = 1'b0;
      tick;
      go = 1'b0;
      n = IW'($urandom); seed0 = $urandom; seed1 = $urandom;
      sat_mode = 1'($urandom); stream_mode = 1'($urandom);
      check({tag, "_busy_at_accept"}, busy, 1);
      check({tag, "_ovf_cleared"}, overflow, 0);

      cyc = 0; first_valid = -1; prev_stall = 1'b0; got_done = 1'b0;
      prev_res = '0; prev_idx = '0;
      while (!got_done && cyc < 3000) begin
         case (rmode)
            0:       result_ready = 1'b1;
            1:       result_ready = cyc[0];
            default: result_ready = ($urandom_range(0, 99) < 60);
         endcase
         if (poke && cyc == 2) begin
            go = 1'b1; n = IW'($urandom); seed0 = $urandom; seed1 = $urandom;
         end else begin
            go = 1'b0;
         end
         if (prev_stall) begin
            check({tag, "_stall_valid"}, result_valid, 1);
            check({tag, "_stall_result"}, result, prev_res);
            check({tag, "_stall_idx"}, result_idx, prev_idx);
         end
         if (result_valid && first_valid < 0) first_valid = cyc;
         if (result_valid && result_ready) begin
            if (exp_q.size() == 0) begin
               check({tag, "_extra_term"}, result_idx, 64'hFFFF);
            end else begin
               check({tag, "_term"}, result, exp_q.pop_front());
               check({tag, "_term_idx"}, result_idx, exp_idx_q.pop_front());
            end
         end
         prev_stall = result_valid && !result_ready;
         prev_res   = result;
         prev_idx   = result_idx;
         if (done) begin
            got_done = 1'b1;
         end else begin
            tick;
            cyc++;
         end
      end

      check({tag, "_done_seen"}, got_done, 1);
      if (got_done) begin
         check({tag, "_done_valid_low"}, result_valid, 0);
         check({tag, "_done_busy"}, busy, 1);
      end
      check({tag, "_terms_left"}, exp_q.size(), 0);
      if (rmode == 0 && !strm) check({tag, "_latency"}, first_valid, nn + 1);
      check({tag, "_result"}, result, mterm[nn]);
      check({tag, "_idx"}, result_idx, nb);
      check({tag, "_ovf"}, overflow, movf);

      go = poke;
      if (poke) begin
         n = IW'($urandom); seed0 = $urandom; seed1 = $urandom;
      end
      tick;
      go = 1'b0;
      result_ready = 1'b0;
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_idle_busy"}, busy, 0);
      check({tag, "_hold_result"}, result, mterm[nn]);
      check({tag, "_hold_ovf"}, overflow, movf);
   endtask

   initial begin
      int done_cnt;
      int rn;
      logic [OW-1:0] r0, r1;

      rst_n = 1'b0;
      repeat (3) tick;
      check_idle_zero("reset");
      rst_n = 1'b1;
      tick;

      run_job("t1_basic", 10, 0, 1, 1'b0, 1'b0, 0, 1'b0);
      check("t1_const", result, 55);

      run_job("t2_n47", 47, 0, 1, 1'b0, 1'b0, 0, 1'b0);
      check("t2_n47_const", result, 32'd2971215073);
      run_job("t2_n48_wrap", 48, 0, 1, 1'b0, 1'b0, 2, 1'b0);
      check("t2_wrap_const", result, 32'd512559680);
      check("t2_wrap_ovf", overflow, 1);
      run_job("t2_n48_sat", 48, 0, 1, 1'b1, 1'b0, 0, 1'b0);
      check("t2_sat_const", result, 32'hFFFF_FFFF);
      check("t2_sat_ovf", overflow, 1);

      run_job("t3_stream", 5, 2, 1, 1'b0, 1'b1, 1, 1'b0);
      check("t3_last_const", result, 11);

      run_job("t4_n0", 0, 123, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 1'b0);
      check("t4_n0_const", result, 123);
      run_job("t4_n1", 1, 5, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 1'b0);
      check("t4_n1_const", result, 32'hFFFF_FFFF);
      check("t4_n1_ovf", overflow, 0);

      run_job("t5_poke", 10, 0, 1, 1'b0, 1'b0, 0, 1'b1);
      check("t5_poke_const", result, 55);

      go = 1'b1; n = 6'd20; seed0 = 0; seed1 = 1; sat_mode = 1'b0; stream_mode = 1'b0;
      tick;
      go = 1'b0;
      repeat (3) tick;
      rst_n = 1'b0;
      tick;
      check_idle_zero("t5_midreset");
      rst_n = 1'b1;
      done_cnt = 0;
      for (int i = 0; i < 30; i++) begin
         tick;
         if (done) done_cnt++;
      end
      check("t5_no_done", done_cnt, 0);

      run_job("t6_ovf", 60, 0, 1, 1'b0, 1'b1, 2, 1'b0);
      check("t6_ovf_set", overflow, 1);
      run_job("t6_clear", 3, 0, 1, 1'b0, 1'b0, 0, 1'b0);
      check("t6_clear_const", result, 2);
      check("t6_clear_ovf", overflow, 0);

      for (int j = 0; j < 12; j++) begin
         rn = $urandom_range(0, 63);
         r0 = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 1000)) : 32'($urandom);
         r1 = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 1000)) : 32'($urandom);
         run_job("rand", rn, r0, r1, 1'($urandom), 1'($urandom), $urandom_range(0, 2), 1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
